// File: rtl/mac_relu_pkg.sv
// Shared types and helpers for the mac_relu_stream dot-product engine.
// Optional out_sat port is enabled by MAC_RELU_STREAM_SAT_FLAG_EN.
package mac_relu_pkg;

  localparam int MAX_OUT_W = 32;

  typedef struct packed {
    logic [MAX_OUT_W-1:0] data;
    logic                 sat;
  } act_res_t;

  function automatic int min_acc_w(
    input int data_w,
    input int vec_len
  );
    return 2 * data_w + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/mac_relu_stream_relu_sat.sv
// Combinational activation: ReLU, right shift, unsigned clamp to OUT_W.
// Reports whether the clamp was active for the current value.
module relu_sat
  import mac_relu_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] sum,
  output act_res_t         res
);

  logic [ACC_W-1:0] pos;
  logic [ACC_W-1:0] shifted;
  logic [OUT_W-1:0] data;
  logic             sat;

  assign pos     = sum[ACC_W-1] ? '0 : sum;
  assign shifted = pos >> SHIFT;

  generate
    if (OUT_W < ACC_W) begin : g_clamp
      assign sat  = |shifted[ACC_W-1:OUT_W];
      assign data = sat ? '1 : shifted[OUT_W-1:0];
    end else begin : g_wide
      assign sat  = 1'b0;
      assign data = OUT_W'(shifted);
    end
  endgenerate

  assign res.data = MAX_OUT_W'(data);
  assign res.sat  = sat;

endmodule

// File: rtl/mac_relu_stream.sv
// Streaming signed dot product with ReLU/shift/saturate output stage.
// Define MAC_RELU_STREAM_SAT_FLAG_EN to expose the out_sat clamp flag.
module mac_relu_stream
  import mac_relu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int VEC_LEN = 16,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
  ,
  output logic              out_sat
`endif
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  generate
    if (ACC_W < min_acc_w(DATA_W, VEC_LEN)) begin : g_acc_chk
      $error("ACC_W too narrow for DATA_W and VEC_LEN");
    end
    if (VEC_LEN < 1 || OUT_W > MAX_OUT_W) begin : g_par_chk
      $error("bad VEC_LEN or OUT_W");
    end
    if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_sh_chk
      $error("SHIFT out of range");
    end
  endgenerate

  logic                       stall;
  logic                       fire;
  logic                       s2_go;
  logic                       s1_valid;
  logic                       s1_last;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] s1_p;
  logic [CNT_W-1:0]           cnt;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           sum;
  act_res_t                   res;
  logic                       unused_res;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rst_n && !stall;
  assign fire     = in_valid && in_ready;
  assign s2_go    = s1_valid && !stall;
  assign prod     = $signed(in_data) * $signed(in_weight);
  assign sum      = acc + ACC_W'(s1_p);

  relu_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_relu_sat (
    .sum(sum),
    .res(res)
  );

  assign unused_res = ^res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else if (clr) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= fire;
      if (fire) begin
        s1_p    <= prod;
        s1_last <= (cnt == LAST);
        cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Not stalled means any held result is being taken this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (s2_go) begin
        if (s1_last) begin
          acc       <= '0;
          out_valid <= 1'b1;
          out_data  <= res.data[OUT_W-1:0];
        end else begin
          acc <= sum;
        end
      end
    end
  end

`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= 1'b0;
    end else if (clr) begin
      out_sat <= 1'b0;
    end else if (s2_go && s1_last) begin
      out_sat <= res.sat;
    end
  end
`endif

endmodule

// File: tb/tb_mac_relu_stream.sv
// Bench for mac_relu_stream: directed scenarios plus randomized vectors
// against a per-vector sum-of-products reference model.
`timescale 1ns/1ps
module tb_mac_relu_stream;

  localparam int DW = 8;
  localparam int AW = 24;
  localparam int VL = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_weight;
  logic          in_ready, in_ready2;
  logic          out_valid, out_valid2;
  logic [OW-1:0] out_data, out_data2;
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
  logic          out_sat, out_sat2;
`endif

  int tests = 0;
  int fails = 0;
  bit collect = 0;
  int got0[$];
  int got2[$];

  always #5 clk = ~clk;

  mac_relu_stream #(
    .DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .SHIFT(0), .OUT_W(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
    , .out_sat(out_sat)
`endif
  );

  mac_relu_stream #(
    .DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .SHIFT(2), .OUT_W(OW)
  ) dut_s2 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2)
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
    , .out_sat(out_sat2)
`endif
  );

  function automatic int act(input int s, input int sh);
    int r;
    r = (s < 0) ? 0 : (s >>> sh);
    return (r > 255) ? 255 : r;
  endfunction

`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
  function automatic bit act_sat(input int s, input int sh);
    return (s >= 0) && ((s >>> sh) > 255);
  endfunction
`endif

  always @(negedge clk) begin
    if (collect && rst_n && out_ready) begin
      if (out_valid) got0.push_back(int'(out_data));
      if (out_valid2) got2.push_back(int'(out_data2));
    end
  end

  task automatic beat(input int d, input int w);
    bit ok;
    ok = 0;
    in_valid  = 1'b1;
    in_data   = DW'(d);
    in_weight = DW'(w);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL beat_timeout in_ready stayed 0, want handshake");
    end
  endtask

  task automatic wait_out();
    int i;
    i = 0;
    while (out_valid !== 1'b1 && i < 50) begin
      @(posedge clk); #1; i++;
    end
    if (out_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL out_timeout out_valid=%0b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = '0; in_weight = '0;
    #2 rst_n = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL rst_data got %0d want 0", out_data); end
    tests++; if (in_ready !== 1'b0 || in_ready2 !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %0b/%0b want 0", in_ready, in_ready2); end
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
    tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL rst_sat got %0b want 0", out_sat); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_exit_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int s;
    out_ready = 1'b1;
    s = 1*2 + 3*4 + 5*6 + 7*8;
    beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early got %0b want 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_valid2 !== 1'b1) begin fails++; $display("FAIL basic_latency got %0b/%0b want 1", out_valid, out_valid2); end
    tests++; if (out_data !== act(s, 0)) begin fails++; $display("FAIL basic_data got %0d want %0d", out_data, act(s, 0)); end
    tests++; if (out_data2 !== act(s, 2)) begin fails++; $display("FAIL basic_shift2 got %0d want %0d", out_data2, act(s, 2)); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse got %0b want 0", out_valid); end
  endtask

  // Table rows: pair (a,b) repeated k times, rest of vector is (0,0).
  task automatic test_act();
    int ta[6] = '{-10, -1, 127, -128, 15, 16};
    int tb[6] = '{5, 1, 127, -128, 17, 16};
    int tk[6] = '{4, 1, 4, 4, 1, 1};
    int s;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < VL; i++) begin
        if (i < tk[t]) beat(ta[t], tb[t]);
        else beat(0, 0);
      end
      wait_out();
      s = ta[t] * tb[t] * tk[t];
      tests++; if (out_data !== act(s, 0)) begin fails++; $display("FAIL act_data[%0d] got %0d want %0d", t, out_data, act(s, 0)); end
      tests++; if (out_data2 !== act(s, 2)) begin fails++; $display("FAIL act_shift2[%0d] got %0d want %0d", t, out_data2, act(s, 2)); end
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
      tests++; if (out_sat !== act_sat(s, 0)) begin fails++; $display("FAIL act_sat[%0d] got %0b want %0b", t, out_sat, act_sat(s, 0)); end
      tests++; if (out_sat2 !== act_sat(s, 2)) begin fails++; $display("FAIL act_sat2[%0d] got %0b want %0b", t, out_sat2, act_sat(s, 2)); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd2; in_weight = 8'd3;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_pre_ready got %0b want 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %0b want 1", c, out_valid); end
      tests++; if (out_data !== 8'd100) begin fails++; $display("FAIL bp_hold[%0d] got %0d want 100", c, out_data); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d] got %0b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    beat(2, 3); beat(2, 3); beat(2, 3);
    wait_out();
    tests++; if (out_data !== act(4 * 6, 0)) begin fails++; $display("FAIL bp_second got %0d want %0d", out_data, act(24, 0)); end
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    tests++; if (cnt != 0) begin fails++; $display("FAIL bp_extra got %0d extra results want 0", cnt); end
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    beat(2, 2); beat(2, 2); beat(2, 2); beat(2, 2);
    out_ready = 1'b0;
    wait_out();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    out_ready = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_pend_valid got %0b want 0", out_valid); end
    tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL clr_pend_data got %0d want 0", out_data); end
`ifdef MAC_RELU_STREAM_SAT_FLAG_EN
    tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL clr_pend_sat got %0b want 0", out_sat); end
`endif
    beat(9, 9); beat(9, 9);
    in_valid = 1'b1; in_data = 8'd50; in_weight = 8'd50; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_mid_valid got %0b want 0", out_valid); end
    beat(1, 1); beat(1, 1); beat(1, 1); beat(1, 1);
    wait_out();
    tests++; if (out_data !== act(4, 0)) begin fails++; $display("FAIL clr_next got %0d want %0d", out_data, act(4, 0)); end
    tests++; if (out_data2 !== act(4, 2)) begin fails++; $display("FAIL clr_next2 got %0d want %0d", out_data2, act(4, 2)); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int cnt;
    out_ready = 1'b1;
    beat(5, 5); beat(5, 5);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin fails++; $display("FAIL arst_mid got v=%0b d=%0d want 0/0", out_valid, out_data); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL arst_mid_ready got %0b want 0", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b0;
    beat(7, 7); beat(7, 7); beat(7, 7); beat(7, 7);
    wait_out();
    tests++; if (out_data !== act(196, 0)) begin fails++; $display("FAIL arst_pre got %0d want 196", out_data); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin fails++; $display("FAIL arst_out got v=%0b d=%0d want 0/0", out_valid, out_data); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL arst_out_ready got %0b want 0", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    tests++; if (cnt != 0) begin fails++; $display("FAIL arst_exit got %0d results want 0", cnt); end
    beat(1, 2); beat(3, 4); beat(5, 6); beat(7, 8);
    wait_out();
    tests++; if (out_data !== act(100, 0)) begin fails++; $display("FAIL arst_fresh got %0d want 100", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int exp0[$];
    int exp2[$];
    int d, w, s, n;
    bit done;
    got0.delete(); got2.delete();
    done = 0; collect = 1;
    fork
      begin
        for (int v = 0; v < 12; v++) begin
          s = 0;
          for (int i = 0; i < VL; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0; @(posedge clk); #1;
            end
            d = int'($urandom_range(0, 255)) - 128;
            w = int'($urandom_range(0, 255)) - 128;
            beat(d, w);
            s += d * w;
          end
          exp0.push_back(act(s, 0));
          exp2.push_back(act(s, 2));
        end
        for (int i = 0; i < 200 && got0.size() < 12; i++) begin
          @(posedge clk); #1;
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        logic [OW-1:0] hold;
        bit stalled;
        stalled = 0; hold = '0;
        while (!done) begin
          @(negedge clk);
          tests++; if (in_ready !== !(out_valid && !out_ready)) begin fails++; $display("FAIL rnd_ready got %0b want %0b", in_ready, !(out_valid && !out_ready)); end
          if (stalled) begin
            tests++; if (out_valid !== 1'b1 || out_data !== hold) begin fails++; $display("FAIL rnd_hold got v=%0b d=%0d want 1/%0d", out_valid, out_data, hold); end
          end
          stalled = out_valid && !out_ready;
          hold = out_data;
        end
      end
    join
    collect = 0;
    tests++; if (got0.size() != exp0.size() || got2.size() != exp2.size()) begin fails++; $display("FAIL rnd_count got %0d/%0d want %0d", got0.size(), got2.size(), exp0.size()); end
    n = (got0.size() < exp0.size()) ? got0.size() : exp0.size();
    for (int i = 0; i < n; i++) begin
      tests++; if (got0[i] != exp0[i]) begin fails++; $display("FAIL rnd_data[%0d] got %0d want %0d", i, got0[i], exp0[i]); end
    end
    n = (got2.size() < exp2.size()) ? got2.size() : exp2.size();
    for (int i = 0; i < n; i++) begin
      tests++; if (got2[i] != exp2[i]) begin fails++; $display("FAIL rnd_shift2[%0d] got %0d want %0d", i, got2[i], exp2[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_act();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
